pipe_stage_hs: RTL
==================

# pipe_stage_hs

Parametrised pipeline stage register with a valid/ready handshake, flush-to-bubble and stall accounting. It is the generalised successor to the fixed Decode→Execute latch. Payload and control widths are set by parameters, so the same block serves ID/EX, EX/MEM and MEM/WB. Unlike the fixed latch, it can stall without losing data, inject NOP bubbles on flush, and report occupancy and stall statistics.

## Interface
- DATA_W, 192, payload width (operands, PC, immediates, cache lane words, flattened by the instantiating stage)
- CTRL_W, 16, control-bit width (WB/MEM/CACHE/BRANCH selects, FUNTYPE, FUNCODE, RD); forced to zero on every bubble
- CNT_W, 16, stall counter width
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard stage contents (branch taken / exception)
- in_valid  in  1  upstream has a transfer
- in_ready  out  1  stage can accept
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  stage holds a valid transfer
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to next stage
- out_ctrl  out  CTRL_W  control to next stage; all zero when out_valid=0
- level  out  2  entries held (0, 1 or 2)
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Upstream transfer occurs when in_valid & in_ready at a posedge. Downstream transfer occurs when out_valid & out_ready at a posedge.
- Storage:
  - main register always drives the outputs.
  - skid register exists only with PIPE_SKID_EN.
- States with skid: EMPTY (level 0), ONE (level 1), FULL (level 2).
  - EMPTY: in fire → ONE, main←input.
  - ONE, in fire & out fire → ONE, main←input.
  - ONE, in fire & !out_ready → FULL, skid←input.
  - ONE, no in fire & out fire → EMPTY.
  - FULL: in_ready=0; out fire → ONE, main←skid.
- States without skid: EMPTY/ONE only. in_ready = !out_valid | out_ready (combinational). Simultaneous in/out fire reloads main.
- Skid mode: in_ready = !skid_valid, taken directly from a flop, with no combinational path from out_ready.
- flush: priority below rst, above all handshakes.
  - Next state EMPTY; main and skid valid cleared.
  - An upstream transfer in the flush cycle is dropped.
  - out_data holds its last value; out_ctrl reads zero.
- out_ctrl is gated by out_valid, so an invalid cycle always presents a NOP.
- stall_cnt increments by 1 in every cycle with out_valid & !out_ready, including the flush cycle. It saturates at 2^CNT_W−1 and never wraps. It is cleared only by rst.
- Data ordering is strictly FIFO; no transfer is duplicated or lost except by flush.

## Timing
- Latency: input accepted at edge N appears on out_* after edge N (valid during cycle N+1). There is no combinational in→out path.
- Throughput: one transfer per cycle while out_ready=1, in both modes.
- Skid mode: after out_ready deasserts, one further input is absorbed. in_ready falls one cycle later, after the edge that fills skid.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, level=0, stall_cnt=0, internal state EMPTY.
- in_ready=0 while rst is high. It is 1 in the first cycle after reset.
- A handshake presented while rst is high is ignored.
- rst asserted mid-operation (FULL, or any state) discards both entries at the next edge. out_valid is 0 in the first cycle after reset.
- flush asserted with out_valid & out_ready in the same cycle: the downstream transfer completes, and the stage is EMPTY afterwards.

## Configuration
- PIPE_SKID_EN defined:
  - Two-entry skid storage; registered in_ready; level can reach 2.
  - Use it to cut the ready timing path across the pipeline.
- PIPE_SKID_EN undefined:
  - Single register; in_ready is combinational from out_valid/out_ready; level ≤ 1.
  - The skid register and its logic are not synthesised.

## Test plan
- Streaming: out_ready=1, in_data=0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 one cycle later each; level=1 throughout; stall_cnt=0.
- Backpressure (skid): hold A=0xA valid, drop out_ready, present B=0xB → level=2, in_ready=0 next cycle; raise out_ready → A then B emitted in order, no loss; stall_cnt equals the number of cycles out_ready was low.
- Flush from FULL: level=2, assert flush with in_valid=1, C=0xC → next cycle out_valid=0, out_ctrl=0, level=0, in_ready=1; C is never emitted.
- Reset mid-stall: level=2, assert rst for 1 cycle → all outputs 0; in_ready=0 during rst and 1 afterwards; no stale entry emitted.
- Counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.
- No-skid build: same backpressure stimulus as scenario 2 → in_ready=0 in the same cycle out_ready=0 while out_valid=1; level never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush-to-bubble and saturating stall count.
// Define PIPE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_hs #(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign stall_cnt = stall_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        level = 2'd0;
        case (state_q)
            ONE:     level = 2'd1;
            FULL:    level = 2'd2;
            default: level = 2'd0;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    // Ready depends only on flops, which breaks the ready path between stages.
    assign in_ready = (state_q != FULL) & ~rst;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (in_fire && out_ready) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end
`else
    assign in_ready = (~out_valid | out_ready) & ~rst;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end else if (out_fire) begin
            state_d = EMPTY;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            stall_q     <= stall_d;
        end
    end

endmodule
